// File: rtl/wb_bram32_ctrl.sv
// Purpose : Wishbone classic slave mapping a byte-addressed window onto a 32-bit BRAM with subword writes.
// Latency : request accepted at edge N, ack/err during the cycle ending at edge N+2; one transfer per 3 cycles.
// Backpr. : no stall; a request is only sampled in IDLE, and dropping i_wb_cyc aborts the transfer silently.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), synchronous active-low reset
//   i_wb_cyc/stb/we        Wishbone cycle, strobe, write flag
//   i_wb_addr/data/sel     byte address ([1:0] ignored), lane-aligned write data, byte-lane select
//   o_wb_data/ack/err      read data (zero unless acking a read), normal / error termination
//   o_bram_addr/data/we    BRAM word address, right-justified write data, write enable
//   o_bram_subaddr         1 = word, 2/3 = half0/half1, 4..7 = byte0..byte3
//   i_bram_data            BRAM read data, valid one cycle after the address
module wb_bram32_ctrl #(
  parameter int          DEPTH      = 512,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [31:0]           i_wb_addr,
  input  logic [31:0]           i_wb_data,
  input  logic [3:0]            i_wb_sel,
  output logic [31:0]           o_wb_data,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [31:0]           o_bram_data,
  output logic                  o_bram_we,
  output logic [2:0]            o_bram_subaddr,
  input  logic [31:0]           i_bram_data
);

  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;

  // Latched request. The offset from BASE_ADDR is stored rather than the raw
  // address so that a reset request field of 0 also drives BRAM address 0.
  logic        req_we;
  logic [31:0] req_off;
  logic [31:0] req_data;
  logic [3:0]  req_sel;
  logic        abort_q;   // i_wb_cyc was seen low during ACCESS

  logic        in_range;
  logic        sel_valid;
  logic        req_ok;
  logic [2:0]  sub_dec;
  logic [31:0] data_dec;

  assign in_range = (req_off < WIN_BYTES);

  // Subword decode: lane pattern selects the BRAM access size and the
  // write data is shifted down so the subword sits at bit 0.
  always_comb begin
    sel_valid = 1'b1;
    sub_dec   = 3'd0;
    data_dec  = 32'h0;
    case (req_sel)
      4'b1111: begin sub_dec = 3'd1; data_dec = req_data;                   end
      4'b0011: begin sub_dec = 3'd2; data_dec = {16'h0, req_data[15:0]};   end
      4'b1100: begin sub_dec = 3'd3; data_dec = {16'h0, req_data[31:16]};  end
      4'b0001: begin sub_dec = 3'd4; data_dec = {24'h0, req_data[7:0]};    end
      4'b0010: begin sub_dec = 3'd5; data_dec = {24'h0, req_data[15:8]};   end
      4'b0100: begin sub_dec = 3'd6; data_dec = {24'h0, req_data[23:16]};  end
      4'b1000: begin sub_dec = 3'd7; data_dec = {24'h0, req_data[31:24]};  end
      default: sel_valid = 1'b0;
    endcase
  end

  // Reads never fail on sel; only range and write-lane shape can error.
  assign req_ok = in_range && (!req_we || sel_valid);

  assign o_bram_addr    = req_off[ADDR_WIDTH+1:2];
  assign o_bram_data    = data_dec;
  assign o_bram_subaddr = sub_dec;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_we   <= 1'b0;
      req_off  <= 32'h0;
      req_data <= 32'h0;
      req_sel  <= 4'h0;
      abort_q  <= 1'b0;
    end else begin
      if (state == IDLE && i_wb_cyc && i_wb_stb) begin
        req_we   <= i_wb_we;
        req_off  <= i_wb_addr - BASE_ADDR;
        req_data <= i_wb_data;
        req_sel  <= i_wb_sel;
      end
      if (state == ACCESS) begin
        abort_q <= !i_wb_cyc;
      end
    end
  end

  // Strobes are gated with i_rst_n so a reset cycle never lets a write or a
  // termination escape before the state register clears.
  always_comb begin
    state_nxt = state;
    o_bram_we = 1'b0;
    o_wb_ack  = 1'b0;
    o_wb_err  = 1'b0;
    o_wb_data = 32'h0;
    case (state)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        o_bram_we = req_we && req_ok && i_wb_cyc && i_rst_n;
      end
      RESP: begin
        state_nxt = IDLE;
        if (!abort_q && i_wb_cyc && i_rst_n) begin
          o_wb_ack = req_ok;
          o_wb_err = !req_ok;
        end
        if (o_wb_ack && !req_we) begin
          o_wb_data = i_bram_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
